// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory (1-cycle read
// latency) between instruction fetch and the data unit (ld/st/ldp/stp).
// Data has priority; fetch is forced after STARVE_MAX consecutive data grants.
// Pair accesses issue their second beat from PAIR2 and cannot be interrupted.
// Optional build macro: MEM_PORT_ARBITER_PERF_EN adds perf_if_stall/perf_pair.
module mem_port_arbiter #(
  parameter int AW         = 15,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_pair,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata0,
  input  logic [DW-1:0] d_wdata1,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [15:0]   perf_if_stall,
  output logic [15:0]   perf_pair
`endif
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic {ARB, PAIR2} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_D} src_t;

  // Captured second beat of a pair access.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } beat_t;

  state_t     state, state_nxt;
  src_t       rd_src;
  beat_t      beat2;
  logic [3:0] starve_cnt;
  logic       fetch_force;

  // Fetch wins over data only once data has starved it STARVE_MAX times.
  assign fetch_force = if_req && (starve_cnt == SMAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  // Next state: a granted pair moves to PAIR2, PAIR2 always returns to ARB.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (d_gnt && d_pair) state_nxt = PAIR2;
      PAIR2:   state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Grants and memory command; everything held off while reset is asserted.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      case (state)
        ARB: begin
          if (d_req && !fetch_force) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata0;
          end else if (if_req) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr;
          end
        end
        PAIR2: begin
          mem_en    = 1'b1;
          mem_we    = beat2.we;
          mem_addr  = beat2.addr;
          mem_wdata = beat2.wdata;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == PAIR2);
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  // Capture the second beat when a pair is granted (address wraps at 2^AW).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat2 <= '0;
    end else if (d_gnt && d_pair) begin
      beat2.we    <= d_we;
      beat2.addr  <= d_addr + 1'b1;
      beat2.wdata <= d_wdata1;
    end
  end

  // Consecutive data grants seen by a waiting fetch, saturating at STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         starve_cnt <= '0;
    else if (if_gnt || !if_req)         starve_cnt <= '0;
    else if (d_gnt && starve_cnt < SMAX) starve_cnt <= starve_cnt + 4'd1;
  end

  // Owner of the read returning next cycle, and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_src <= SRC_NONE;
      d_done <= 1'b0;
    end else begin
      if (d_gnt && !d_we)                 rd_src <= SRC_D;
      else if (if_gnt)                    rd_src <= SRC_IF;
      else if (state == PAIR2 && !beat2.we) rd_src <= SRC_D;
      else                                rd_src <= SRC_NONE;
      d_done <= (d_gnt && !d_pair) || (state == PAIR2);
    end
  end

  assign if_rvalid = (rd_src == SRC_IF);
  assign d_rvalid  = (rd_src == SRC_D);

`ifdef MEM_PORT_ARBITER_PERF_EN
  // Saturating fetch-stall and completed-pair counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_stall <= '0;
      perf_pair     <= '0;
    end else begin
      if (if_req && !if_gnt && perf_if_stall != 16'hFFFF)
        perf_if_stall <= perf_if_stall + 16'd1;
      if (state == PAIR2 && perf_pair != 16'hFFFF)
        perf_pair <= perf_pair + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple synchronous memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, d_pair;
  logic [14:0] if_addr, d_addr;
  logic [15:0] d_wdata0, d_wdata1;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_done, mem_en, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [14:0] mem_addr;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0] perf_if_stall, perf_pair;
`endif

  logic [15:0] mem [0:32767];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(15), .DW(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_pair(d_pair), .d_addr(d_addr),
    .d_wdata0(d_wdata0), .d_wdata1(d_wdata1), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_PORT_ARBITER_PERF_EN
    , .perf_if_stall(perf_if_stall), .perf_pair(perf_pair)
`endif
  );

  // Single-ported synchronous memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle's request inputs at the falling edge, settle before checks.
  task automatic cyc(input logic ifr, input logic [14:0] ifa, input logic dr,
                     input logic dwe, input logic dp, input logic [14:0] da,
                     input logic [15:0] w0, input logic [15:0] w1);
    @(negedge clk);
    if_req = ifr; if_addr = ifa;
    d_req = dr; d_we = dwe; d_pair = dp; d_addr = da;
    d_wdata0 = w0; d_wdata1 = w1;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 15'h0, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] <= 16'h0;
    for (int i = 0; i < 4; i++) mem[i] <= 16'hA000 + 16'(i);
    mem_rdata <= 16'h0;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 15'h5;
    d_req = 1'b1; d_we = 1'b0; d_pair = 1'b0; d_addr = 15'h7;
    d_wdata0 = 16'h0; d_wdata1 = 16'h0;
    #2;
    // Reset: no grants or memory activity even with requests pending.
    chk("rst_mem_en", mem_en, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    @(negedge clk); #1;
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_busy", busy, 0);
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("rst_perf_stall", perf_if_stall, 0);
    chk("rst_perf_pair", perf_pair, 0);
`endif
    if_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b1;

    // Fetch only, consecutive addresses.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 15'(k), 1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 16'h0);
      chk("if_gnt", if_gnt, 1);
      chk("if_mem_addr", mem_addr, k);
      chk("if_mem_we", mem_we, 0);
      if (k > 0) begin
        chk("if_rvalid", if_rvalid, 1);
        chk("if_rdata", if_rdata, 32'hA000 + k - 1);
      end
    end
    idle();
    chk("if_rvalid_last", if_rvalid, 1);
    chk("if_rdata_last", if_rdata, 32'hA003);
    chk("idle_mem_en", mem_en, 0);

    // Single store then load at the same address.
    cyc(1'b0, 15'h0, 1'b1, 1'b1, 1'b0, 15'h10, 16'h1234, 16'h0);
    chk("st_d_gnt", d_gnt, 1);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 32'h10);
    chk("st_mem_wdata", mem_wdata, 32'h1234);
    chk("st_if_rvalid", if_rvalid, 0);
    cyc(1'b0, 15'h0, 1'b1, 1'b0, 1'b0, 15'h10, 16'h0, 16'h0);
    chk("st_d_done", d_done, 1);
    chk("ld_d_gnt", d_gnt, 1);
    chk("ld_mem_we", mem_we, 0);
    chk("st_d_rvalid", d_rvalid, 0);
    idle();
    chk("ld_d_rvalid", d_rvalid, 1);
    chk("ld_d_rdata", d_rdata, 32'h1234);
    chk("ld_d_done", d_done, 1);

    // Pair store across the address wrap, then pair load back to back.
    cyc(1'b0, 15'h0, 1'b1, 1'b1, 1'b1, 15'h7FFF, 16'h1111, 16'h2222);
    chk("stp_d_gnt", d_gnt, 1);
    chk("stp_addr0", mem_addr, 32'h7FFF);
    chk("stp_wdata0", mem_wdata, 32'h1111);
    chk("stp_busy0", busy, 0);
    chk("stp_done_early", d_done, 0);
    cyc(1'b0, 15'h0, 1'b1, 1'b0, 1'b1, 15'h7FFF, 16'h0, 16'h0);
    chk("stp_busy1", busy, 1);
    chk("stp_pair2_d_gnt", d_gnt, 0);
    chk("stp_pair2_en", mem_en, 1);
    chk("stp_pair2_we", mem_we, 1);
    chk("stp_addr1_wrap", mem_addr, 0);
    chk("stp_wdata1", mem_wdata, 32'h2222);
    chk("stp_no_done_p2", d_done, 0);
    // ldp granted in the cycle stp completes; fetch raised in the same cycle.
    cyc(1'b1, 15'h2, 1'b1, 1'b0, 1'b1, 15'h7FFF, 16'h0, 16'h0);
    chk("stp_d_done", d_done, 1);
    chk("ldp_d_gnt", d_gnt, 1);
    chk("ldp_if_gnt", if_gnt, 0);
    chk("ldp_addr0", mem_addr, 32'h7FFF);
    chk("ldp_busy0", busy, 0);
    cyc(1'b1, 15'h2, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 16'h0);
    chk("ldp_busy1", busy, 1);
    chk("ldp_if_withheld", if_gnt, 0);
    chk("ldp_addr1_wrap", mem_addr, 0);
    chk("ldp_we1", mem_we, 0);
    chk("ldp_rvalid0", d_rvalid, 1);
    chk("ldp_rdata0", d_rdata, 32'h1111);
    chk("ldp_done_early", d_done, 0);
    cyc(1'b1, 15'h2, 1'b0, 1'b0, 1'b0, 15'h0, 16'h0, 16'h0);
    chk("ldp_if_gnt_after", if_gnt, 1);
    chk("ldp_if_addr", mem_addr, 2);
    chk("ldp_rvalid1", d_rvalid, 1);
    chk("ldp_rdata1", d_rdata, 32'h2222);
    chk("ldp_d_done", d_done, 1);
    idle();
    chk("ldp_if_rvalid", if_rvalid, 1);
    chk("ldp_if_rdata", if_rdata, 32'hA002);
    chk("ldp_d_rvalid_off", d_rvalid, 0);
    chk("ldp_done_off", d_done, 0);
    chk("wrap_mem_7fff", mem[15'h7FFF], 32'h1111);
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("perf_pair_2", perf_pair, 2);
`endif

    // Starvation bound: 4 data grants then 1 fetch grant, repeating.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 15'h1, 1'b1, 1'b0, 1'b0, 15'h10, 16'h0, 16'h0);
      chk("stv_if_gnt", if_gnt, (i % 5 == 4) ? 1 : 0);
      chk("stv_d_gnt", d_gnt, (i % 5 == 4) ? 0 : 1);
    end
    idle();

    // Reset while in PAIR2, with starve count nonzero from a waiting fetch.
    cyc(1'b1, 15'h3, 1'b1, 1'b1, 1'b1, 15'h20, 16'h5555, 16'h6666);
    chk("rp_d_gnt", d_gnt, 1);
    chk("rp_if_gnt", if_gnt, 0);
    @(negedge clk);
    d_req = 1'b0;
    #1;
    chk("rp_busy", busy, 1);
    chk("rp_addr1", mem_addr, 32'h21);
    rst_n = 1'b0;
    #1;
    chk("rp_mem_en_off", mem_en, 0);
    chk("rp_busy_off", busy, 0);
    @(negedge clk); #1;
    chk("rp_no_done", d_done, 0);
    chk("rp_beat2_aborted", mem[15'h21], 0);
    chk("rp_beat1_written", mem[15'h20], 32'h5555);
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("rp_perf_stall", perf_if_stall, 0);
    chk("rp_perf_pair", perf_pair, 0);
`endif
    if_req = 1'b0;
    rst_n = 1'b1;
    // A cleared starve count gives four data grants before the fetch.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 15'h1, 1'b1, 1'b0, 1'b0, 15'h10, 16'h0, 16'h0);
      if (i == 0) chk("rp_post_done", d_done, 0);
      chk("rp_stv_if_gnt", if_gnt, (i == 4) ? 1 : 0);
      chk("rp_stv_d_gnt", d_gnt, (i == 4) ? 0 : 1);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
